// File: rtl/fault_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fault_pkg
//  Description : Shared definitions for the stuck-at line tester: FSM state
//                encoding and the pattern-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fault_pkg;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_WAIT  = 2'd1;
    localparam logic [1:0] C_ST_CHECK = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    // all-0, all-1, WIDTH walking-1 and WIDTH walking-0 patterns
    function automatic int npat(input int width);
        return 2 * width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fault_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fault_pattern_gen
//  Description : Combinational test-pattern lookup, index -> pattern.
//                idx 0 all-0, idx 1 all-1, idx 2..WIDTH+1 walking-1,
//                idx WIDTH+2..2*WIDTH+1 walking-0. Out-of-range -> all-0.
//  Ports       : i_idx     [IDX_W-1:0]  pattern index
//                o_pattern [WIDTH-1:0]  pattern value
//  Revision    : 1.0  initial release
// ============================================================================
module fault_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [WIDTH-1:0] o_pattern
);

    logic [WIDTH-1:0] w_walk1;
    logic [WIDTH-1:0] w_walk0;

    always_comb begin
        w_walk1 = '0;
        w_walk0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_walk1[i] = (int'(i_idx) == i + 2);
            w_walk0[i] = (int'(i_idx) == i + WIDTH + 2);
        end
    end

    always_comb begin
        if (i_idx == IDX_W'(1)) begin
            o_pattern = '1;
        end else if (|w_walk0) begin
            o_pattern = ~w_walk0;
        end else begin
            o_pattern = w_walk1;    // also covers idx 0 (all-0)
        end
    end

endmodule
`default_nettype wire

// File: rtl/stuck_fault_detector.sv
`default_nettype none
// ============================================================================
//  Module      : stuck_fault_detector
//  Description : Drives a fixed sequence of test patterns onto a WIDTH-bit
//                line bus, holds each for SETTLE cycles, samples the returned
//                bus and accumulates sticky per-line stuck-at-0/1 flags.
//                Optional macro FAULT_COUNT_EN adds err_cnt, a saturating
//                count of CHECK cycles that saw any mismatch.
//  Ports       : clk, rst_n (async, active-low)
//                start, clear          run / flag-clear requests (IDLE only)
//                tp_in  [WIDTH-1:0]    returned line values
//                tp_out [WIDTH-1:0]    driven test pattern
//                busy, done            run status / end-of-run pulse
//                sa0, sa1 [WIDTH-1:0]  stuck-at-0 / stuck-at-1 flags
//                fault                 any flag set
//                err_cnt [7:0]         (FAULT_COUNT_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module stuck_fault_detector
    import fault_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] tp_in,
    output logic [WIDTH-1:0] tp_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sa0,
    output logic [WIDTH-1:0] sa1,
`ifdef FAULT_COUNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             fault
);

    localparam int NPAT  = npat(WIDTH);
    localparam int IDX_W = $clog2(NPAT);
    localparam int CNT_W = $clog2(SETTLE) + 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_tp_out;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sa0;
    logic [WIDTH-1:0] r_sa1;
    logic [7:0]       r_err_cnt;

    logic [IDX_W-1:0] w_next_idx;
    logic [WIDTH-1:0] w_next_pat;
    logic [WIDTH-1:0] w_miss0;
    logic [WIDTH-1:0] w_miss1;
    logic             w_any_miss;

    assign w_next_idx = r_idx + IDX_W'(1);

    // r_tp_out always holds P(r_idx) during WAIT/CHECK, so the generator is
    // only needed for the pattern that follows.
    fault_pattern_gen #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pattern_gen (
        .i_idx     (w_next_idx),
        .o_pattern (w_next_pat)
    );

    assign w_miss0    = r_tp_out & ~tp_in;
    assign w_miss1    = ~r_tp_out & tp_in;
    assign w_any_miss = |(w_miss0 | w_miss1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= C_ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_tp_out  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sa0     <= '0;
            r_sa1     <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    r_done <= 1'b0;
                    // start has priority; a run clears the flags itself
                    if (start) begin
                        r_tp_out  <= '0;    // pattern 0 is all-0
                        r_idx     <= '0;
                        r_cnt     <= '0;
                        r_sa0     <= '0;
                        r_sa1     <= '0;
                        r_err_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= C_ST_WAIT;
                    end else if (clear) begin
                        r_sa0     <= '0;
                        r_sa1     <= '0;
                        r_err_cnt <= '0;
                    end
                end
                C_ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= C_ST_CHECK;
                    end
                end
                C_ST_CHECK: begin
                    r_sa0 <= r_sa0 | w_miss0;
                    r_sa1 <= r_sa1 | w_miss1;
                    if (w_any_miss && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (r_idx != C_LAST_IDX) begin
                        r_idx    <= w_next_idx;
                        r_tp_out <= w_next_pat;
                        r_cnt    <= '0;
                        r_state  <= C_ST_WAIT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= C_ST_DONE;
                    end
                end
                C_ST_DONE: begin
                    r_done   <= 1'b0;
                    r_tp_out <= '0;
                    r_state  <= C_ST_IDLE;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign tp_out = r_tp_out;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sa0    = r_sa0;
    assign sa1    = r_sa1;
    assign fault  = (|r_sa0) | (|r_sa1);

`ifdef FAULT_COUNT_EN
    assign err_cnt = r_err_cnt;
`else
    // counter is kept for uniform FSM code; without the port it has no load
    // and is removed by synthesis
    logic w_err_cnt_unused;
    assign w_err_cnt_unused = ^r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stuck_fault_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stuck_fault_detector
//  Description : Self-checking bench for stuck_fault_detector (WIDTH=4,
//                SETTLE=4). Each started run pushes its expected end-of-run
//                record; a monitor pops and compares on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stuck_fault_detector;

    typedef struct {
        int          cyc;
        logic [3:0]  sa0;
        logic [3:0]  sa1;
        logic        fault;
        logic [7:0]  err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] tp_in;
    logic [3:0] tp_out;
    logic       busy;
    logic       done;
    logic [3:0] sa0;
    logic [3:0] sa1;
    logic       fault;
    logic [7:0] err_val;
`ifdef FAULT_COUNT_EN
    logic [7:0] err_cnt;
    assign err_val = err_cnt;
`else
    assign err_val = 8'd0;
`endif

    logic [3:0] tp_d = 4'd0;
    logic [3:0] and_mask = 4'hF;
    logic [3:0] or_mask  = 4'h0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];

    stuck_fault_detector #(
        .WIDTH  (4),
        .SETTLE (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .clear   (clear),
        .tp_in   (tp_in),
        .tp_out  (tp_out),
        .busy    (busy),
        .done    (done),
        .sa0     (sa0),
        .sa1     (sa1),
`ifdef FAULT_COUNT_EN
        .err_cnt (err_cnt),
`endif
        .fault   (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tp_d <= tp_out;
    end

    assign tp_in = (tp_d & and_mask) | or_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: every done pulse must match the oldest outstanding run
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_sa0", {28'd0, sa0}, {28'd0, e.sa0});
                check("done_sa1", {28'd0, sa1}, {28'd0, e.sa1});
                check("done_fault", {31'd0, fault}, {31'd0, e.fault});
                check("done_busy", {31'd0, busy}, 32'd0);
`ifdef FAULT_COUNT_EN
                check("done_err_cnt", {24'd0, err_val}, {24'd0, e.err});
`endif
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // start a run in the current cycle and register its expected outcome
    task automatic go(output int c, input logic [3:0] esa0, input logic [3:0] esa1,
                      input logic [7:0] eerr, input logic with_clear);
        exp_t e;
        c = cyc;
        e.cyc = c + 51; e.sa0 = esa0; e.sa1 = esa1;
        e.fault = |{esa0, esa1}; e.err = eerr;
        q.push_back(e);
        start = 1'b1;
        clear = with_clear;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic cl);
        start = s;
        clear = cl;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("rst_tp_out", {28'd0, tp_out}, 32'd0);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_flags",  {24'd0, sa0, sa1}, 32'd0);
        check("rst_fault",  {31'd0, fault},  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // run 1: clean loopback, stray start mid-run
        go(c, 4'b0000, 4'b0000, 8'd0, 1'b0);
        check("r1_busy_first", {31'd0, busy}, 32'd1);
        check("r1_pat0", {28'd0, tp_out}, 32'h0);
        wait_until(c + 6);
        check("r1_pat1", {28'd0, tp_out}, 32'hF);
        wait_until(c + 16);
        check("r1_pat3_walk1", {28'd0, tp_out}, 32'h2);
        wait_until(c + 20);
        pulse(1'b1, 1'b0);
        wait_until(c + 36);
        check("r1_pat7_walk0", {28'd0, tp_out}, 32'hD);
        wait_until(c + 50);
        check("r1_busy_last", {31'd0, busy}, 32'd1);
        wait_until(c + 52);
        check("r1_idle_busy", {31'd0, busy}, 32'd0);
        check("r1_idle_tp_out", {28'd0, tp_out}, 32'd0);
        check("r1_fault", {31'd0, fault}, 32'd0);
        repeat (2) @(negedge clk);

        // run 2: line 2 stuck at 0; mismatches at idx 1,4,6,7,9
        and_mask = 4'b1011;
        go(c, 4'b0100, 4'b0000, 8'd5, 1'b0);
        wait_until(c + 10);
        check("r2_fault_before", {31'd0, fault}, 32'd0);
        @(negedge clk);
        check("r2_fault_rise", {31'd0, fault}, 32'd1);
        wait_until(c + 20);
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("r2_clear_busy_ignored", {28'd0, sa0}, 32'h4);
        wait_until(c + 53);
        check("r2_sticky_sa0", {28'd0, sa0}, 32'h4);
        pulse(1'b0, 1'b1);
        check("r2_clear_sa0", {28'd0, sa0}, 32'd0);
        check("r2_clear_fault", {31'd0, fault}, 32'd0);
        and_mask = 4'hF;
        repeat (2) @(negedge clk);

        // run 3: line 0 stuck at 1; mismatches at idx 0,3,4,5,6
        or_mask = 4'b0001;
        go(c, 4'b0000, 4'b0001, 8'd5, 1'b0);
        wait_until(c + 5);
        check("r3_fault_before", {31'd0, fault}, 32'd0);
        @(negedge clk);
        check("r3_fault_rise", {31'd0, fault}, 32'd1);
        wait_until(c + 53);
        check("r3_sticky_sa1", {28'd0, sa1}, 32'h1);
        or_mask = 4'h0;

        // run 4: start+clear together, then aborted by reset (no done)
        c = cyc;
        pulse(1'b1, 1'b1);
        check("r4_start_clears_sa1", {28'd0, sa1}, 32'd0);
        check("r4_busy", {31'd0, busy}, 32'd1);
        wait_until(c + 20);
        rst_n = 1'b0;
        #1;
        check("r4_abort_busy", {31'd0, busy}, 32'd0);
        check("r4_abort_tp_out", {28'd0, tp_out}, 32'd0);
        check("r4_abort_fault", {31'd0, fault}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // run 5: full sequence after reset release
        go(c, 4'b0000, 4'b0000, 8'd0, 1'b0);
        wait_until(c + 50);
        check("r5_busy_last", {31'd0, busy}, 32'd1);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("missing_done", 32'd0, e.cyc);
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
